// File: rtl/keypad_emu_pkg.sv
// Shared definitions for the keypad emulator: FSM state encoding, LFSR
// constants and default phase lengths.
package keypad_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_BOUNCE_PRESS   = 3'd1,
        ST_HOLD           = 3'd2,
        ST_BOUNCE_RELEASE = 3'd3,
        ST_GAP            = 3'd4
    } state_t;

    localparam int         CNT_W     = 16;

    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 (stage n is bit n-1 of a left-shifting register).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int DEF_BOUNCE_CYCLES = 16;
    localparam int DEF_GAP_CYCLES    = 8;

    // A zero-length phase would never see its "last cycle" marker, so zero
    // lengths are stretched to a single cycle.
    function automatic logic [CNT_W-1:0] len_min1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used as a pseudo-random contact-bounce source.
// Free-running; reseeded by rst so bounce patterns are repeatable.
module lfsr8
    import keypad_emu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb = ^(r_lfsr & LFSR_TAPS);
    assign out  = r_lfsr;

    // Shift every cycle; a non-zero seed keeps the register out of the
    // all-zero lock-up state forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: accepts key-press commands and plays them back to a
// row-scanning keypad controller as a contact closure on one column line.
// Optional contact bounce is enabled with the macro KEYPAD_EMU_BOUNCE_EN;
// without it the sequence is IDLE -> HOLD -> GAP -> IDLE.
module keypad_emulator
    import keypad_emu_pkg::*;
#(
    parameter int BOUNCE_CYCLES = DEF_BOUNCE_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_row,
    input  logic [1:0]  cmd_col,
    input  logic [15:0] cmd_hold,
    input  logic [3:0]  keypadRow,
    output logic [3:0]  keypadCol,
    output logic        busy,
    output logic        done
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load;
    logic [CNT_W-1:0] w_hold_src;
    logic [1:0]       r_row;
    logic [1:0]       r_col;
    logic [15:0]      r_hold;
    logic             r_contact;
    logic             w_accept;
    logic             w_last;
    logic             w_lfsr_bit;
    logic [3:0]       w_col;

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [LFSR_W-1:0] w_lfsr;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (w_lfsr)
    );

    assign w_lfsr_bit = w_lfsr[0];
`else
    assign w_lfsr_bit = 1'b0;
`endif

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_last    = (r_cnt == CNT_W'(1));
    assign done      = (r_state == ST_GAP) && w_last;

    // When HOLD is entered straight from IDLE the command is being latched
    // in the same cycle, so the hold length must come from the input port.
    assign w_hold_src = (r_state == ST_IDLE) ? cmd_hold : r_hold;

    // Next-state selection: each active phase advances on its last cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    w_next = ST_BOUNCE_PRESS;
`else
                    w_next = ST_HOLD;
`endif
                end
            end
            ST_BOUNCE_PRESS: begin
                if (w_last) w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_last) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    w_next = ST_BOUNCE_RELEASE;
`else
                    w_next = ST_GAP;
`endif
                end
            end
            ST_BOUNCE_RELEASE: begin
                if (w_last) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Duration loaded into the counter on entry to the next phase.
    always_comb begin
        w_load = '0;
        case (w_next)
            ST_BOUNCE_PRESS,
            ST_BOUNCE_RELEASE: w_load = len_min1(CNT_W'(BOUNCE_CYCLES));
            ST_HOLD:           w_load = len_min1(w_hold_src);
            ST_GAP:            w_load = len_min1(CNT_W'(GAP_CYCLES));
            default:           w_load = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase counter: load on every state change, then count down to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= w_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Command latch; fields offered while busy are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_hold <= '0;
        end else if (w_accept) begin
            r_row  <= cmd_row;
            r_col  <= cmd_col;
            r_hold <= cmd_hold;
        end
    end

    // Contact state, registered from the current phase so the column line
    // is glitch-free with respect to FSM decoding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_contact <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD:           r_contact <= 1'b1;
                ST_BOUNCE_PRESS,
                ST_BOUNCE_RELEASE: r_contact <= w_lfsr_bit;
                default:           r_contact <= 1'b0;
            endcase
        end
    end

    // Column sense follows the row drive with zero latency: the closed
    // switch only pulls its column low while the scanner drives its row low.
    always_comb begin
        w_col = 4'b1111;
        if (r_contact && !keypadRow[r_row]) begin
            w_col[r_col] = 1'b0;
        end
    end

    assign keypadCol = w_col;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator. The reference model is a phase
// timeline computed from the command: busy for 2*B+H+G cycles after
// acceptance, contact visible during the hold window, done on the last
// busy cycle. Bounce-specific checks are compiled with KEYPAD_EMU_BOUNCE_EN.
module tb_keypad_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BNC = 16;
`else
    localparam int BNC = 0;
`endif
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_row;
    logic [1:0]  cmd_col;
    logic [15:0] cmd_hold;
    logic [3:0]  keypadRow;
    logic [3:0]  keypadCol;
    logic        busy;
    logic        done;

    logic        z_cmd_valid;
    logic        z_cmd_ready;
    logic [1:0]  z_cmd_row;
    logic [1:0]  z_cmd_col;
    logic [15:0] z_cmd_hold;
    logic [3:0]  z_keypadRow;
    logic [3:0]  z_keypadCol;
    logic        z_busy;
    logic        z_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(16), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_hold  (cmd_hold),
        .keypadRow (keypadRow),
        .keypadCol (keypadCol),
        .busy      (busy),
        .done      (done)
    );

    keypad_emulator #(.BOUNCE_CYCLES(16), .GAP_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (z_cmd_valid),
        .cmd_ready (z_cmd_ready),
        .cmd_row   (z_cmd_row),
        .cmd_col   (z_cmd_col),
        .cmd_hold  (z_cmd_hold),
        .keypadRow (z_keypadRow),
        .keypadCol (z_keypadCol),
        .busy      (z_busy),
        .done      (z_done)
    );

    function automatic logic [3:0] exp_col(input bit contact, input logic [1:0] row,
                                           input logic [1:0] col, input logic [3:0] krow);
        logic [3:0] one;
        one = 4'b0001;
        if (contact && (krow[row] == 1'b0)) return ~(one << col);
        return 4'b1111;
    endfunction

    // Issue one command and check every cycle until the emulator is idle again.
    task automatic run_cmd(input logic [1:0] row, input logic [1:0] col,
                           input logic [15:0] hold, input logic [3:0] krow,
                           input bit rand_row, input int max_wait, input bit keep_valid,
                           input logic [1:0] nrow, input logic [1:0] ncol,
                           input logic [15:0] nhold, input string name);
        int   h, p, w;
        bit   in_hold, in_b;
        logic e_busy, e_done, e_ready;
        logic [3:0] e_col;
`ifdef KEYPAD_EMU_BOUNCE_EN
        int   tog_p, tog_r;
        bit   prev, cur, seen;
        tog_p = 0; tog_r = 0; prev = 1'b0; seen = 1'b0;
`endif
        h = (hold == 16'd0) ? 1 : int'(hold);
        p = 2 * BNC + h + GAP;
        cmd_row = row; cmd_col = col; cmd_hold = hold;
        keypadRow = krow; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL %s accept: cmd_ready=%b required 1", name, cmd_ready);
            n_fail++;
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (keep_valid) begin
            cmd_row = nrow; cmd_col = ncol; cmd_hold = nhold;
        end else begin
            cmd_valid = 1'b0;
            cmd_row = 2'($urandom); cmd_col = 2'($urandom); cmd_hold = 16'($urandom);
        end
        for (int k = 1; k <= p + 1; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (rand_row) keypadRow = 4'($urandom);
            @(negedge clk);
            in_hold = (k >= 2 + BNC) && (k <= 1 + BNC + h);
            in_b    = ((k >= 2) && (k <= 1 + BNC)) ||
                      ((k >= 2 + BNC + h) && (k <= 1 + 2 * BNC + h));
            e_busy  = (k <= p);
            e_ready = (k > p);
            e_done  = (k == p);
            n_checks++;
            if (busy !== e_busy) begin
                $display("FAIL %s busy k=%0d: got %b required %b", name, k, busy, e_busy);
                n_fail++;
            end
            n_checks++;
            if (cmd_ready !== e_ready) begin
                $display("FAIL %s cmd_ready k=%0d: got %b required %b", name, k, cmd_ready, e_ready);
                n_fail++;
            end
            n_checks++;
            if (done !== e_done) begin
                $display("FAIL %s done k=%0d: got %b required %b", name, k, done, e_done);
                n_fail++;
            end
            if (!in_b) begin
                e_col = exp_col(in_hold, row, col, keypadRow);
                n_checks++;
                if (keypadCol !== e_col) begin
                    $display("FAIL %s keypadCol k=%0d: got %b required %b", name, k, keypadCol, e_col);
                    n_fail++;
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (k == 2 || k == 2 + BNC + h) seen = 1'b0;
            if (in_b && keypadRow[row] == 1'b0) begin
                cur = ~keypadCol[col];
                if (seen && cur != prev) begin
                    if (k <= 1 + BNC) tog_p++;
                    else tog_r++;
                end
                prev = cur;
                seen = 1'b1;
            end
`endif
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (!rand_row && krow[row] == 1'b0) begin
            n_checks++;
            if (tog_p == 0 || tog_r == 0) begin
                $display("FAIL %s bounce toggles: press=%0d release=%0d required both >0",
                         name, tog_p, tog_r);
                n_fail++;
            end
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1; z_cmd_valid = 1'b0;
        cmd_row = 2'd3; cmd_col = 2'd3; cmd_hold = 16'd4;
        keypadRow = 4'b0000; z_keypadRow = 4'b1111;
        z_cmd_row = '0; z_cmd_col = '0; z_cmd_hold = '0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                $display("FAIL reset_accept: busy=%b required 0", busy);
                n_fail++;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || keypadCol !== 4'b1111) begin
            $display("FAIL reset_state: ready=%b done=%b col=%b required 1 0 1111",
                     cmd_ready, done, keypadCol);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        run_cmd(2'd2, 2'd1, 16'd5, 4'b1011, 1'b0, 20, 1'b0, '0, '0, '0, "row_match");
    endtask

    task automatic test_row_mask();
        run_cmd(2'd2, 2'd1, 16'd5, 4'b1110, 1'b0, 20, 1'b0, '0, '0, '0, "row_mask");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_cmd(2'($urandom), 2'($urandom), (i == 0) ? 16'd0 : 16'($urandom_range(12)),
                    4'($urandom), 1'b1, 20, 1'b0, '0, '0, '0, "random");
        end
    endtask

`ifdef KEYPAD_EMU_BOUNCE_EN
    task automatic test_bounce();
        run_cmd(2'd1, 2'd0, 16'd10, 4'b1101, 1'b0, 20, 1'b0, '0, '0, '0, "bounce");
    endtask
`endif

    task automatic test_back_to_back();
        run_cmd(2'd1, 2'd3, 16'd4, 4'b0000, 1'b0, 20, 1'b1, 2'd3, 2'd0, 16'd6, "b2b_first");
        run_cmd(2'd3, 2'd0, 16'd6, 4'b0000, 1'b0, 0,  1'b0, '0, '0, '0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int w;
        cmd_row = 2'd0; cmd_col = 2'd2; cmd_hold = 16'd30;
        keypadRow = 4'b0000; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (BNC + 4) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (keypadCol !== 4'b1011) begin
            $display("FAIL mid_hold_col: got %b required 1011", keypadCol);
            n_fail++;
        end
        rst = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (keypadCol !== 4'b1111 || cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL mid_reset: col=%b ready=%b done=%b busy=%b required 1111 1 0 0",
                     keypadCol, cmd_ready, done, busy);
            n_fail++;
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        n_checks++;
        if (dut.u_lfsr.out !== 8'hA5) begin
            $display("FAIL mid_reset_lfsr: got %h required a5", dut.u_lfsr.out);
            n_fail++;
        end
`endif
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL mid_reset_no_accept: busy=%b required 0", busy);
            n_fail++;
        end
    endtask

    task automatic test_zero_lengths();
        int   w, p, dones;
        logic e_busy, e_done;
        logic [3:0] e_col;
        p = 2 * BNC + 2;
        dones = 0;
        z_cmd_row = 2'd1; z_cmd_col = 2'd2; z_cmd_hold = 16'd0;
        z_keypadRow = 4'b1101; z_cmd_valid = 1'b1;
        w = 0;
        while (!z_cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        z_cmd_valid = 1'b0;
        for (int k = 1; k <= p + 1; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            e_busy = (k <= p);
            e_done = (k == p);
            if (z_done === 1'b1) dones++;
            n_checks++;
            if (z_busy !== e_busy || z_done !== e_done) begin
                $display("FAIL zero_len k=%0d: busy=%b done=%b required %b %b",
                         k, z_busy, z_done, e_busy, e_done);
                n_fail++;
            end
            if (!(((k >= 2) && (k <= 1 + BNC)) || ((k >= 3 + BNC) && (k <= 2 + 2 * BNC)))) begin
                e_col = exp_col(k == 2 + BNC, 2'd1, 2'd2, z_keypadRow);
                n_checks++;
                if (z_keypadCol !== e_col) begin
                    $display("FAIL zero_len_col k=%0d: got %b required %b", k, z_keypadCol, e_col);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (dones != 1) begin
            $display("FAIL zero_len_done_count: got %0d required 1", dones);
            n_fail++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_row_mask();
        test_random();
`ifdef KEYPAD_EMU_BOUNCE_EN
        test_bounce();
`endif
        test_back_to_back();
        test_reset_mid();
        test_zero_lengths();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 16: length of each contact-bounce phase, in clk cycles.
REQ-002 Parameter GAP_CYCLES, default 8: forced-open interval after release, in clk cycles.
REQ-003 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port cmd_valid, input, 1: a key-press command is offered.
REQ-006 Port cmd_ready, output, 1: the emulator can accept a command.
REQ-007 Port cmd_row, input, 2: row of the key to press, 0..3.
REQ-008 Port cmd_col, input, 2: column of the key to press, 0..3.
REQ-009 Port cmd_hold, input, 16: number of clk cycles the contact stays stably closed.
REQ-010 Port keypadRow, input, 4: row drive from the keypad scanner, active-low.
REQ-011 Port keypadCol, output, 4: column sense returned to the scanner, active-low, idle high.
REQ-012 Port busy, output, 1: a command is in progress.
REQ-013 Port done, output, 1: one-cycle pulse marking command completion.

Function
REQ-014 FSM states: IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE, GAP.
REQ-015 cmd_ready is 1 only in IDLE; busy equals NOT cmd_ready.
REQ-016 A command is accepted when cmd_valid and cmd_ready are both 1 in cycle N.
- cmd_row, cmd_col and cmd_hold are latched in cycle N.
- The FSM leaves IDLE in cycle N+1.
REQ-017 Inputs other than cmd_valid are ignored while cmd_ready is 0; a held cmd_valid is accepted on return to IDLE.
REQ-018 Phase durations:
- BOUNCE_PRESS: BOUNCE_CYCLES cycles.
- HOLD: cmd_hold cycles; cmd_hold=0 is treated as 1.
- BOUNCE_RELEASE: BOUNCE_CYCLES cycles.
- GAP: GAP_CYCLES cycles; GAP_CYCLES=0 is treated as 1.
- Each phase is then followed by the next state in REQ-014 order, and GAP by IDLE.
REQ-019 Duration counters are 16-bit, load at phase entry and count down; counter equal to 1 marks the last cycle of the phase.
REQ-020 Registered contact signal:
- 0 in IDLE and GAP.
- 1 in HOLD.
- lfsr[0] in BOUNCE_PRESS and BOUNCE_RELEASE.
REQ-021 keypadCol[c] is 0 exactly when contact=1, c equals the latched column, and keypadRow[latched row] is 0; every other bit is 1.
REQ-022 keypadCol is combinational from contact and keypadRow, so row-to-column latency is zero cycles.
REQ-023 Any number of low bits in keypadRow is legal, including 4'b0000; only the latched row's bit matters.
REQ-024 done is 1 for exactly one cycle, the last GAP cycle; cmd_ready rises in the following cycle.
REQ-025 LFSR behaviour:
- 8-bit Fibonacci LFSR, taps 8,6,5,4.
- Advances every cycle regardless of state.
- Never reaches the value 0.

Reset
REQ-026 On rst=1 at a clock edge, the block is set to the following values, including when a command is in progress:
- FSM state IDLE, contact=0, counters 0, LFSR=8'hA5.
- Latched row 0, latched column 0.
- done=0, busy=0, cmd_ready=1.
- keypadCol=4'b1111 from the next cycle.
REQ-027 A command offered in a cycle with rst=1 is not accepted.

Configuration
REQ-028 With macro KEYPAD_EMU_BOUNCE_EN defined, the behaviour is as in REQ-018 and REQ-020.
REQ-029 Without KEYPAD_EMU_BOUNCE_EN:
- BOUNCE_PRESS and BOUNCE_RELEASE are never entered; the sequence is IDLE -> HOLD -> GAP -> IDLE.
- The LFSR is not instantiated.
- BOUNCE_CYCLES is unused.

Structure
REQ-030 Shared package keypad_emu_pkg holds:
- the state enumeration;
- LFSR width, seed 8'hA5 and tap mask;
- the default BOUNCE_CYCLES and GAP_CYCLES values.
REQ-031 The LFSR is a separate sub-module lfsr8 (clk, rst, out[7:0]).

Verification
REQ-032 Bounce disabled:
- Stimulus: BOUNCE_EN undefined, command row=2 col=1 hold=5, keypadRow=4'b1011 constant.
- Response: keypadCol=4'b1101 for exactly 5 cycles beginning 2 cycles after acceptance, then 4'b1111; done pulses GAP_CYCLES cycles later.
REQ-033 Row masking:
- Stimulus: same command, keypadRow=4'b1110.
- Response: keypadCol stays 4'b1111 throughout; done still pulses.
REQ-034 Bounce enabled:
- Stimulus: BOUNCE_EN defined, BOUNCE_CYCLES=16, command hold=10.
- Response: total busy time 16+10+16+8 = 50 cycles; at least one contact toggle in each bounce phase; HOLD is stably closed.
REQ-035 Back-to-back commands:
- Stimulus: cmd_valid held high with two commands.
- Response: the second command is accepted in the cycle after done; cmd_ready is never 1 while busy=1.
REQ-036 Reset mid-operation:
- Stimulus: rst asserted during HOLD.
- Response: next cycle keypadCol=4'b1111, cmd_ready=1, done=0, LFSR=8'hA5.
REQ-037 Zero lengths:
- Stimulus: hold=0, GAP_CYCLES=0.
- Response: HOLD lasts 1 cycle, GAP lasts 1 cycle, done pulses once.
